fp_round_stage: RTL and testbench

//  Rounding stage that sits directly downstream of the FP normalizer. It takes the normalized

---
 rtl/fp_round_stage.sv | 171 +++++++++++++++++
 tb/tb_fp_round_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_round_stage.sv
// fp_round_stage: IEEE 754 rounding stage behind the FP normalizer.
// Two-stage valid/ready pipeline; packs {sign,exp,frac} and exception flags.
//
// Ports:
//   clk, rst (sync, active-high), ce (global enable)
//   valid_i/ready_o : upstream handshake
//   sign_i, exp_i, man_i {whole,frac,guard,round}, sticky_i, under_i, rm_i
//   valid_o/ready_i : downstream handshake
//   o {sign,exp,frac}, inexact_o, over_o, under_o
//
// Build option: FP_ROUND_FLAGS_EN
//   defined   -> flags computed and pipelined with the data
//   undefined -> flags tied to 0, no flag flops
module fp_round_stage #(
   parameter int FPWID = 32,
   parameter int EMSB  = (FPWID == 16)  ? 4  :
                         (FPWID == 64)  ? 10 :
                         (FPWID == 128) ? 14 : 7,
   parameter int FMSB  = FPWID - EMSB - 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              sign_i,
   input  logic [EMSB:0]     exp_i,
   input  logic [FMSB+3:0]   man_i,
   input  logic              sticky_i,
   input  logic              under_i,
   input  logic [2:0]        rm_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [FPWID-1:0]  o,
   output logic              inexact_o,
   output logic              over_o,
   output logic              under_o
);

   logic en;
   assign en      = ce & (~valid_o | ready_i);
   assign ready_o = en;

   // ---------------- stage 1: round decision
   logic g, r, lsb, spec, rup_raw, rup;
   logic rm_rtz, rm_rdn, rm_rup, rm_rmm;

   assign lsb  = man_i[2];
   assign g    = man_i[1];
   assign r    = man_i[0];
   assign spec = &exp_i;

   assign rm_rtz = (rm_i == 3'b001);
   assign rm_rdn = (rm_i == 3'b010);
   assign rm_rup = (rm_i == 3'b011);
   assign rm_rmm = (rm_i == 3'b100);

   // Unlisted encodings fall through to round-to-nearest-even.
   always_comb begin
      rup_raw = g & (r | sticky_i | lsb);
      unique case (1'b1)
         rm_rtz:  rup_raw = 1'b0;
         rm_rdn:  rup_raw = sign_i & (g | r | sticky_i);
         rm_rup:  rup_raw = ~sign_i & (g | r | sticky_i);
         rm_rmm:  rup_raw = g;
         default: ;
      endcase
   end

   // Inf/NaN pass through untouched.
   assign rup = rup_raw & ~spec;

   logic            v1;
   logic            s1_sign;
   logic [EMSB:0]   s1_exp;
   logic [FMSB+1:0] s1_man;
   logic            s1_rup;
   logic            s1_spec;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_exp  <= '0;
         s1_man  <= '0;
         s1_rup  <= 1'b0;
         s1_spec <= 1'b0;
      end else if (en) begin
         v1      <= valid_i;
         s1_sign <= sign_i;
         s1_exp  <= exp_i;
         s1_man  <= man_i[FMSB+3:2];
         s1_rup  <= rup;
         s1_spec <= spec;
      end
   end

   // ---------------- stage 2: increment and pack
   localparam logic [EMSB:0] EXP_ONE = {{EMSB{1'b0}}, 1'b1};

   logic [FMSB+2:0] sum;
   logic            carry;
   logic [EMSB:0]   exp_inc;
   logic [EMSB:0]   exp_n;
   logic [FMSB:0]   frac_n;

   assign sum     = {1'b0, s1_man} + {{(FMSB+2){1'b0}}, s1_rup};
   assign carry   = sum[FMSB+2];
   assign exp_inc = s1_exp + EXP_ONE;

   // A carry into an all-ones exponent leaves frac=0, i.e. infinity.
   // A denormal rounding up into whole=1 becomes the smallest normal.
   always_comb begin
      exp_n  = s1_exp;
      frac_n = sum[FMSB:0];
      if (s1_spec) begin
         frac_n = s1_man[FMSB:0];
      end else if (carry) begin
         exp_n  = exp_inc;
         frac_n = '0;
      end else if (s1_exp == '0 && sum[FMSB+1]) begin
         exp_n  = EXP_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         o       <= '0;
      end else if (en) begin
         valid_o <= v1;
         o       <= {s1_sign, exp_n, frac_n};
      end
   end

`ifdef FP_ROUND_FLAGS_EN
   logic x, ovf;
   logic s1_x, s1_under;
   logic inexact_r, over_r, under_r;

   assign x   = (g | r | sticky_i) & ~spec;
   assign ovf = ~s1_spec & carry & (&exp_inc);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_x      <= 1'b0;
         s1_under  <= 1'b0;
         inexact_r <= 1'b0;
         over_r    <= 1'b0;
         under_r   <= 1'b0;
      end else if (en) begin
         s1_x      <= x;
         s1_under  <= under_i;
         inexact_r <= s1_x | ovf;
         over_r    <= ovf;
         under_r   <= s1_under & s1_x;
      end
   end

   assign inexact_o = inexact_r;
   assign over_o    = over_r;
   assign under_o   = under_r;
`else
   logic unused_under;
   assign unused_under = under_i;
   assign inexact_o    = 1'b0;
   assign over_o       = 1'b0;
   assign under_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_round_stage.sv
// tb_fp_round_stage: directed vectors for fp_round_stage (FPWID=32).
// Flag expectations are zero unless FP_ROUND_FLAGS_EN is defined.
module tb_fp_round_stage;

   logic        clk = 1'b0;
   logic        rst, ce, valid_i, ready_o, sign_i;
   logic [7:0]  exp_i;
   logic [25:0] man_i;
   logic        sticky_i, under_i;
   logic [2:0]  rm_i;
   logic        valid_o, ready_i;
   logic [31:0] o;
   logic        inexact_o, over_o, under_o;

   int checks = 0;
   int errors = 0;
   int n;
   int waits;
   logic [31:0] expv [4];

   always #5 clk = ~clk;

   fp_round_stage #(.FPWID(32)) dut (
      .clk(clk), .rst(rst), .ce(ce),
      .valid_i(valid_i), .ready_o(ready_o),
      .sign_i(sign_i), .exp_i(exp_i), .man_i(man_i),
      .sticky_i(sticky_i), .under_i(under_i), .rm_i(rm_i),
      .valid_o(valid_o), .ready_i(ready_i), .o(o),
      .inexact_o(inexact_o), .over_o(over_o), .under_o(under_o)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef FP_ROUND_FLAGS_EN
      return f;
`else
      return (f & 3'b000);
`endif
   endfunction

   // grs = {guard, round, sticky}
   task automatic drive(input logic s, input logic [7:0] e,
                        input logic w, input logic [22:0] f,
                        input logic [2:0] grs, input logic u,
                        input logic [2:0] rm);
      sign_i   = s;
      exp_i    = e;
      man_i    = {w, f, grs[2:1]};
      sticky_i = grs[0];
      under_i  = u;
      rm_i     = rm;
   endtask

   // want_fl = {inexact, over, under}
   task automatic run1(input string tag, input logic s,
                       input logic [7:0] e, input logic w,
                       input logic [22:0] f, input logic [2:0] grs,
                       input logic u, input logic [2:0] rm,
                       input logic [31:0] want_o,
                       input logic [2:0] want_fl);
      drive(s, e, w, f, grs, u, rm);
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".v"}, valid_o, 1);
      chk(tag, o, want_o);
      chk({tag, ".fl"}, {inexact_o, over_o, under_o}, fl(want_fl));
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      drive(0, 8'h00, 0, 23'h0, 3'b000, 0, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      chk("rst.v", valid_o, 0);
      chk("rst.o", o, 0);
      chk("rst.fl", {inexact_o, over_o, under_o}, 0);
      chk("rst.rdy", ready_o, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      run1("rne_tie", 0, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd0,
           32'h3F800002, 3'b100);
      run1("rm5_rne", 0, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd5,
           32'h3F800002, 3'b100);
      run1("rtz", 0, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd1,
           32'h3F800001, 3'b100);
      run1("rup_neg", 1, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd3,
           32'hBF800001, 3'b100);
      run1("rdn_neg", 1, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd2,
           32'hBF800002, 3'b100);
      run1("rne_even", 0, 8'h7F, 1, 23'h000002, 3'b100, 0, 3'd0,
           32'h3F800002, 3'b100);
      run1("rmm", 0, 8'h7F, 1, 23'h000002, 3'b100, 0, 3'd4,
           32'h3F800003, 3'b100);
      run1("exact", 0, 8'h7F, 1, 23'h000002, 3'b000, 0, 3'd3,
           32'h3F800002, 3'b000);
      run1("ovf", 0, 8'hFE, 1, 23'h7FFFFF, 3'b100, 0, 3'd0,
           32'h7F800000, 3'b110);
      run1("ovf_rtz", 0, 8'hFE, 1, 23'h7FFFFF, 3'b100, 0, 3'd1,
           32'h7F7FFFFF, 3'b100);
      run1("nan", 0, 8'hFF, 1, 23'h400001, 3'b111, 0, 3'd0,
           32'h7FC00001, 3'b000);
      run1("nan_rup", 0, 8'hFF, 1, 23'h400001, 3'b111, 0, 3'd3,
           32'h7FC00001, 3'b000);
      run1("denorm", 0, 8'h00, 0, 23'h7FFFFF, 3'b100, 1, 3'd0,
           32'h00800000, 3'b101);
      run1("negzero", 1, 8'h00, 0, 23'h000000, 3'b000, 0, 3'd0,
           32'h80000000, 3'b000);

      // ce low freezes the pipeline
      drive(0, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd0);
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      ce = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("ce.hold", valid_o, 0);
      end
      ce = 1'b1;
      @(posedge clk); #1;
      chk("ce.v", valid_o, 1);
      chk("ce.o", o, 32'h3F800002);
      @(posedge clk); #1;

      // stream of 4 beats with a 3-cycle downstream stall
      for (int i = 0; i < 4; i++) expv[i] = 32'h40000011 + i;
      n = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               drive(0, 8'h80, 1, 23'h000010 + i, 3'b110, 0, 3'd0);
               valid_i = 1'b1;
               waits = 0;
               @(negedge clk);
               while (!ready_o && waits < 50) begin
                  waits++;
                  @(negedge clk);
               end
               if (waits >= 50) chk("strm.tmo", waits, 0);
               @(posedge clk); #1;
            end
            valid_i = 1'b0;
         end
         begin
            repeat (3) @(posedge clk);
            #1 ready_i = 1'b0;
            repeat (3) @(posedge clk);
            #1 ready_i = 1'b1;
         end
         begin
            for (int c = 0; c < 30; c++) begin
               @(negedge clk);
               if (valid_o) begin
                  if (n < 4) chk("strm.o", o, expv[n]);
                  else chk("strm.extra", n, 3);
                  if (ready_i) n++;
               end
            end
         end
      join
      chk("strm.n", n, 4);
      chk("strm.idle", valid_o, 0);

      // reset with two beats in flight
      @(posedge clk); #1;
      drive(0, 8'h7F, 1, 23'h000001, 3'b100, 0, 3'd0);
      valid_i = 1'b1;
      @(posedge clk); #1;
      drive(0, 8'h80, 1, 23'h000005, 3'b000, 0, 3'd0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mrst.v", valid_o, 0);
      chk("mrst.o", o, 0);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("mrst.stale", valid_o, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
